// File: rtl/lane_background.sv
// ---------------------------------------------------------------------------
// lane_background
//   Two-stage pipelined background renderer for the Frogger playfield.
//   Each visible pixel is mapped to a 12-bit RGB colour from a vertical stack
//   of lanes. The lanes are, from top to bottom:
//     - goal grass
//     - river lanes
//     - median grass
//     - road lanes
//     - start grass
//   River and road lanes carry a stripe pattern that scrolls once per frame.
//   Each of these lanes has its own scroll period and direction.
//
//   Optional feature macro: LANE_BG_SCROLL_EN
//     defined   : per-lane offset/frame counters are built; frame_tick and
//                 pause control scrolling.
//     undefined : offsets are constant zero, so the patterns are static.
//                 frame_tick and pause are ignored.
//
// Ports
//   clk        in  1   pixel clock
//   reset      in  1   asynchronous, active-high reset
//   on         in  1   video-active flag from the VGA timing block
//   x          in  10  pixel column
//   y          in  10  pixel row
//   frame_tick in  1   one-cycle pulse per frame (start of vblank)
//   pause      in  1   freezes all scrolling while high
//   rgb        out 12  registered colour, 2 cycles after x/y/on are sampled
// ---------------------------------------------------------------------------
module lane_background #(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int LANE_SHIFT   = 5,
  parameter int RIVER_LANES  = 6,
  parameter int ROAD_LANES   = 6,
  parameter int STRIPE_SHIFT = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        on,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        frame_tick,
  input  logic        pause,
  output logic [11:0] rgb
);

  localparam int NUM_LANES = RIVER_LANES + ROAD_LANES + 3;
  localparam int NSCR      = RIVER_LANES + ROAD_LANES;
  localparam int LW        = 10 - LANE_SHIFT;
  localparam int JW        = (NSCR > 1) ? $clog2(NSCR) : 1;

  localparam logic [11:0] GREEN      = 12'h0F0;
  localparam logic [11:0] BLACK      = 12'h000;
  localparam logic [11:0] BLUE       = 12'h00F;
  localparam logic [11:0] LIGHT_BLUE = 12'h08F;
  localparam logic [11:0] WHITE      = 12'hFFF;

  // Lane boundaries, expressed as lane indices.
  localparam logic [LW-1:0] L_RIVER_LAST = LW'(RIVER_LANES);
  localparam logic [LW-1:0] L_MEDIAN     = LW'(RIVER_LANES + 1);
  localparam logic [LW-1:0] L_ROAD_FIRST = LW'(RIVER_LANES + 2);
  localparam logic [LW-1:0] L_ROAD_LAST  = LW'(RIVER_LANES + ROAD_LANES + 1);
  localparam logic [LW-1:0] L_START      = LW'(NUM_LANES - 1);
  localparam logic [LW-1:0] L_END        = LW'(NUM_LANES);

  // The bottom two rows of a road lane carry the dash line.
  localparam logic [LANE_SHIFT-1:0] DASH_ROW = LANE_SHIFT'((1 << LANE_SHIFT) - 2);

  // Current scroll offset of every scrolling lane.
  // Scroll index j maps to lanes as follows:
  //   river lanes: j = L-1
  //   road lanes : j = L-2
  logic [STRIPE_SHIFT-1:0] off_val [NSCR];

  genvar gi;

`ifdef LANE_BG_SCROLL_EN
  generate
    for (gi = 0; gi < NSCR; gi++) begin : g_scroll
      localparam int PERIOD   = (gi % 3) + 1;
      localparam int LANE_IDX = (gi < RIVER_LANES) ? gi + 1 : gi + 2;
      // Odd lanes scroll by incrementing the offset.
      // Even lanes scroll by decrementing it.
      localparam bit INC      = (LANE_IDX % 2) == 1;

      logic [STRIPE_SHIFT-1:0] off_reg;
      logic [1:0]              fc_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          off_reg <= '0;
          fc_reg  <= '0;
        end else if (frame_tick && !pause) begin
          if (fc_reg == 2'(PERIOD - 1)) begin
            fc_reg  <= '0;
            off_reg <= INC ? off_reg + STRIPE_SHIFT'(1) : off_reg - STRIPE_SHIFT'(1);
          end else begin
            fc_reg <= fc_reg + 2'd1;
          end
        end
      end

      assign off_val[gi] = off_reg;
    end
  endgenerate
`else
  generate
    for (gi = 0; gi < NSCR; gi++) begin : g_static
      assign off_val[gi] = '0;
    end
  endgenerate

  logic unused_scroll_inputs;
  assign unused_scroll_inputs = &{1'b0, frame_tick, pause};
`endif

  // ---------------- stage 1: decode coordinate ----------------
  logic [LW-1:0]           lane_next;
  logic [LANE_SHIFT-1:0]   row_next;
  logic [JW-1:0]           scroll_idx;
  logic [STRIPE_SHIFT-1:0] sx_next;
  logic                    in_range_next;

  always_comb begin
    lane_next  = y[9:LANE_SHIFT];
    row_next   = y[LANE_SHIFT-1:0];
    scroll_idx = '0;
    if (lane_next >= LW'(1) && lane_next <= L_RIVER_LAST)
      scroll_idx = JW'(lane_next - LW'(1));
    else if (lane_next >= L_ROAD_FIRST && lane_next <= L_ROAD_LAST)
      scroll_idx = JW'(lane_next - LW'(2));
    // Uses the offset before any same-edge update, so a coincident tick
    // only affects later pixels.
    sx_next       = x[STRIPE_SHIFT-1:0] + off_val[scroll_idx];
    in_range_next = (x < 10'(H_RES)) && (y < 10'(V_RES)) && (lane_next < L_END);
  end

  logic [LW-1:0]         lane_reg;
  logic [LANE_SHIFT-1:0] row_reg;
  logic                  s_reg;       // only the stripe bit of sx is consumed
  logic                  in_range_reg;
  logic                  on_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_reg     <= '0;
      row_reg      <= '0;
      s_reg        <= 1'b0;
      in_range_reg <= 1'b0;
      on_reg       <= 1'b0;
    end else begin
      lane_reg     <= lane_next;
      row_reg      <= row_next;
      s_reg        <= sx_next[STRIPE_SHIFT-1];
      in_range_reg <= in_range_next;
      on_reg       <= on;
    end
  end

  // ---------------- stage 2: colour lookup ----------------
  logic [11:0] rgb_next;
  logic [11:0] rgb_reg;

  always_comb begin
    rgb_next = BLACK;
    if (on_reg && in_range_reg) begin
      if (lane_reg == '0 || lane_reg == L_MEDIAN || lane_reg == L_START)
        rgb_next = GREEN;
      else if (lane_reg <= L_RIVER_LAST)
        rgb_next = s_reg ? LIGHT_BLUE : BLUE;
      // The remaining in-range lanes are road lanes.
      // The last road lane borders the start grass and has no dash line.
      else if (lane_reg != L_ROAD_LAST && row_reg >= DASH_ROW)
        rgb_next = s_reg ? BLACK : WHITE;
      else
        rgb_next = BLACK;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rgb_reg <= BLACK;
    else       rgb_reg <= rgb_next;
  end

  assign rgb = rgb_reg;

endmodule

// File: doc/lane_background.md
# lane_background

Parametrised, pipelined background renderer for the Frogger playfield. It maps each visible pixel coordinate from the VGA timing block to a 12-bit RGB colour, using a configurable stack of horizontal lanes: goal grass, river lanes, median grass, road lanes and start grass. River and road lanes carry stripe/dash patterns that scroll once per frame at per-lane speeds and directions. Its output feeds the sprite mixer, which overlays the frog, cars and logs.

## Interface
Parameters:
- `H_RES`, 640, visible width in pixels; `x >= H_RES` renders BLACK.
- `V_RES`, 480, visible height; `y >= V_RES` renders BLACK.
- `LANE_SHIFT`, 5, lane height = 2^LANE_SHIFT rows.
- `RIVER_LANES`, 6, number of river lanes (>=1).
- `ROAD_LANES`, 6, number of road lanes (>=1).
- `STRIPE_SHIFT`, 5, pattern period = 2^STRIPE_SHIFT px; scroll offsets are STRIPE_SHIFT bits wide.
- Derived: NUM_LANES = RIVER_LANES + ROAD_LANES + 3.

Ports:
- `clk` in 1: pixel clock.
- `reset` in 1: asynchronous, active-high.
- `on` in 1: video-active flag from the VGA timing block.
- `x` in 10: pixel column.
- `y` in 10: pixel row.
- `frame_tick` in 1: single-cycle pulse, once per frame (start of vblank).
- `pause` in 1: freezes all scrolling while high.
- `rgb` out 12: registered colour.

## Operation
- Lane index L = y >> LANE_SHIFT; in-lane row r = y[LANE_SHIFT-1:0].
- Lane map:
  - L=0: grass.
  - L=1..RIVER_LANES: river.
  - L=RIVER_LANES+1: median grass.
  - Next ROAD_LANES lanes: road.
  - L=NUM_LANES-1: start grass.
  - L>=NUM_LANES: BLACK.
- Colours: GREEN 12'h0F0, BLACK 12'h000, BLUE 12'h00F, LIGHT_BLUE 12'h08F, WHITE 12'hFFF.
- Scrolling lane j: river lanes are j=0..RIVER_LANES-1, road lanes continue j=RIVER_LANES onward. Each has an offset register off[j] (STRIPE_SHIFT bits) and a 2-bit frame counter fc[j].
- Period p[j] = (j mod 3)+1 frames.
- On `frame_tick` with `pause`=0:
  - If fc[j]==p[j]-1: step off[j] and clear fc[j].
  - Otherwise: fc[j]++.
- Step direction: odd lane index L increments off (mod 2^STRIPE_SHIFT); even L decrements it (mod 2^STRIPE_SHIFT).
- `pause`=1 on a tick: off and fc both hold.
- sx = (x + off[j]) mod 2^STRIPE_SHIFT; s = sx[STRIPE_SHIFT-1].
- River: s==0 gives BLUE, otherwise LIGHT_BLUE.
- Road:
  - Rows r >= 2^LANE_SHIFT-2 of every road lane except the last carry a dash line: WHITE when s==0, else BLACK.
  - All other road rows are BLACK.
- Grass: GREEN, no pattern.
- Priority: `on`=0 → BLACK; out of range (x/y limits or L>=NUM_LANES) → BLACK; otherwise the lane colour.
- Every output path assigns `rgb` (no hold/latch).

## Timing
- Reset: `rgb`=12'h000, all off[j]=0, all fc[j]=0, pipeline valid/on flags=0.
- Pipeline: two stages.
  - Stage 1 registers L, r, sx, range flags and `on`.
  - Stage 2 registers `rgb`.
- Latency: a coordinate presented at edge N appears on `rgb` after edge N+2. Throughput is one pixel per clock, with no stalls.
- Stage 1 uses the off value before any update at the same edge: a `frame_tick` coincident with a pixel affects only pixels sampled on later edges.
- `reset` asserted mid-frame: `rgb` goes to BLACK immediately (asynchronously) and scroll state clears. After release, the first valid colour appears 2 edges later.
- Offsets wrap silently at 2^STRIPE_SHIFT. fc never exceeds 2.

## Configuration
- `LANE_BG_SCROLL_EN` defined: scroll counters and `pause` behave as specified above.
- Undefined: off/fc registers are not built and off[j] is treated as constant 0. Patterns are static; `frame_tick` and `pause` are ignored. Latency stays 2 cycles.

## Test plan
(All cases use defaults, macro defined.)
- Reset released, on=1, x=100, y=5 -> rgb=12'h0F0 at edge +2; while reset is held, rgb=12'h000.
- Zero offsets, x=15, y=40 (lane 1, river) -> 12'h00F; then one frame_tick, same pixel -> 12'h08F (off[0]=1, sx=16).
- x=0, y=286 (lane 8, road dash row) -> 12'hFFF; after one tick -> 12'h000 (off=31). Row y=280 -> 12'h000 always.
- Lane 3 (j=2, p=3): 2 ticks -> off unchanged; 3rd tick -> off=1. With pause=1, 5 ticks -> off and fc unchanged.
- on=0, or x=640, or y=480 -> 12'h000; y=230 (lane 7, median) -> 12'h0F0.
- Stream alternating coordinates every clock -> each rgb matches its coordinate exactly 2 cycles later; async reset pulse mid-stream -> rgb=12'h000 at once, offsets=0.
